// File: rtl/usb_defs.sv
// Shared USB constants and the bulk-IN scheduler state encoding.
// The helper maps the current bus speed onto the bulk-IN packet size.
package usb_defs;

  localparam int BLK_PKT_HS = 512;
  localparam int BLK_PKT_FS = 64;

  // Packet length and byte counter width; wide enough for a full HS packet.
  localparam int PKT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } blk_state_e;

  function automatic logic [PKT_W-1:0] pkt_size(input logic hs);
    return hs ? PKT_W'(BLK_PKT_HS) : PKT_W'(BLK_PKT_FS);
  endfunction

endpackage

// File: rtl/bulk_in_scheduler_flush_ager.sv
// Per-source flush ager: counts SOF ticks while a source holds a partial packet
// and flags the source eligible when it has a full packet or has waited long enough.
module flush_ager
  import usb_defs::*;
#(
  parameter int LEVEL_BITS = 11,
  parameter int FLUSH_SOFS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_configured,
  input  logic                  i_sof_tick,
  input  logic                  i_clear,
  input  logic [LEVEL_BITS-1:0] i_level,
  input  logic [PKT_W-1:0]      i_pkt,
  output logic                  o_elig
);

  logic [7:0] r_age;
  logic       w_nonzero;
  logic       w_full;
  logic       w_partial;

  assign w_nonzero = |i_level;
  assign w_full    = 32'(i_level) >= 32'(i_pkt);
  assign w_partial = w_nonzero && !w_full;

  // A DONE clear beats a coincident SOF tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_age <= '0;
    end else if (i_clear || !w_partial) begin
      r_age <= '0;
    end else if (i_sof_tick && (r_age != 8'hFF)) begin
      r_age <= r_age + 8'd1;
    end
  end

  assign o_elig = i_configured &&
                  (w_full || (w_nonzero && (r_age >= 8'(FLUSH_SOFS))));

endmodule

// File: rtl/bulk_in_scheduler.sv
// Round-robin bulk-IN scheduler: shares the bridge's single bulk-IN stream
// between a loop-back FIFO (A) and a telemetry stream (B), one packet per grant.
module bulk_in_scheduler
  import usb_defs::*;
#(
  parameter logic [3:0] ENDPOINT   = 4'd1,
  parameter int         LEVEL_BITS = 11,
  parameter int         FLUSH_SOFS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  configured_i,
  input  logic                  usb_hs_i,
  input  logic                  usb_sof_i,
  input  logic                  blk_start_i,
  input  logic                  blk_cycle_i,
  input  logic [3:0]            blk_endpt_i,
  output logic                  blk_in_ready_o,
  output logic [1:0]            grant_o,
  input  logic [LEVEL_BITS-1:0] a_level_i,
  input  logic                  a_tvalid,
  input  logic                  a_tlast,
  input  logic [7:0]            a_tdata,
  output logic                  a_tready,
  input  logic [LEVEL_BITS-1:0] b_level_i,
  input  logic                  b_tvalid,
  input  logic                  b_tlast,
  input  logic [7:0]            b_tdata,
  output logic                  b_tready,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  output logic                  m_tkeep,
  output logic [7:0]            m_tdata,
  input  logic                  m_tready
);

  blk_state_e r_state;
  blk_state_e w_next;

  logic                  r_sof_d;
  logic                  r_ready;
  logic                  r_last_b;
  logic                  r_sel_b;
  logic [PKT_W-1:0]      r_len;
  logic [PKT_W-1:0]      r_count;

  logic                  w_sof_tick;
  logic [PKT_W-1:0]      w_pkt;
  logic                  w_elig_a;
  logic                  w_elig_b;
  logic                  w_grant_ok;
  logic                  w_pick_b;
  logic [LEVEL_BITS-1:0] w_level_sel;
  logic [PKT_W-1:0]      w_len_grant;
  logic                  w_src_tvalid;
  logic                  w_src_tlast;
  logic [7:0]            w_src_tdata;
  logic                  w_tlast;
  logic                  w_hs;
  logic                  w_clear_a;
  logic                  w_clear_b;

  assign w_sof_tick = usb_sof_i && !r_sof_d;
  assign w_pkt      = pkt_size(usb_hs_i);
  assign w_clear_a  = (r_state == ST_DONE) && !r_sel_b;
  assign w_clear_b  = (r_state == ST_DONE) &&  r_sel_b;

  flush_ager #(.LEVEL_BITS(LEVEL_BITS), .FLUSH_SOFS(FLUSH_SOFS)) u_ager_a (
    .clock        (clock),
    .reset        (reset),
    .i_configured (configured_i),
    .i_sof_tick   (w_sof_tick),
    .i_clear      (w_clear_a),
    .i_level      (a_level_i),
    .i_pkt        (w_pkt),
    .o_elig       (w_elig_a)
  );

  flush_ager #(.LEVEL_BITS(LEVEL_BITS), .FLUSH_SOFS(FLUSH_SOFS)) u_ager_b (
    .clock        (clock),
    .reset        (reset),
    .i_configured (configured_i),
    .i_sof_tick   (w_sof_tick),
    .i_clear      (w_clear_b),
    .i_level      (b_level_i),
    .i_pkt        (w_pkt),
    .o_elig       (w_elig_b)
  );

  // On a tie the source that was not served last wins.
  assign w_pick_b    = w_elig_b && (!w_elig_a || !r_last_b);
  assign w_grant_ok  = blk_start_i && (blk_endpt_i == ENDPOINT) && (w_elig_a || w_elig_b);
  assign w_level_sel = w_pick_b ? b_level_i : a_level_i;
  assign w_len_grant = (32'(w_level_sel) >= 32'(w_pkt)) ? w_pkt : w_level_sel[PKT_W-1:0];

  assign w_src_tvalid = r_sel_b ? b_tvalid : a_tvalid;
  assign w_src_tlast  = r_sel_b ? b_tlast  : a_tlast;
  assign w_src_tdata  = r_sel_b ? b_tdata  : a_tdata;
  assign w_tlast      = w_src_tlast || (r_count == (r_len - PKT_W'(1)));
  assign w_hs         = (r_state == ST_XFER) && w_src_tvalid && m_tready;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_grant_ok) w_next = ST_XFER;
      ST_XFER: begin
        if (!blk_cycle_i)          w_next = ST_IDLE;
        else if (w_hs && w_tlast)  w_next = ST_DONE;
      end
      ST_DONE: if (!blk_cycle_i) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    blk_in_ready_o = 1'b0;
    grant_o        = 2'b00;
    m_tvalid       = 1'b0;
    m_tlast        = 1'b0;
    m_tkeep        = 1'b0;
    m_tdata        = 8'h00;
    a_tready       = 1'b0;
    b_tready       = 1'b0;
    unique case (r_state)
      ST_IDLE: blk_in_ready_o = r_ready;
      ST_XFER: begin
        grant_o  = r_sel_b ? 2'b10 : 2'b01;
        m_tvalid = w_src_tvalid;
        m_tkeep  = w_src_tvalid;
        m_tdata  = w_src_tdata;
        m_tlast  = w_tlast;
        a_tready = !r_sel_b && m_tready;
        b_tready =  r_sel_b && m_tready;
      end
      ST_DONE: grant_o = r_sel_b ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  // Pointer starts at B so that A wins the first tie; an abort leaves it untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sof_d  <= 1'b0;
      r_ready  <= 1'b0;
      r_last_b <= 1'b1;
      r_sel_b  <= 1'b0;
      r_len    <= '0;
      r_count  <= '0;
    end else begin
      r_sof_d <= usb_sof_i;
      r_ready <= w_elig_a || w_elig_b;
      if ((r_state == ST_IDLE) && w_grant_ok) begin
        r_sel_b <= w_pick_b;
        r_len   <= w_len_grant;
        r_count <= '0;
      end else if (w_hs) begin
        r_count <= r_count + PKT_W'(1);
      end
      if (r_state == ST_DONE) begin
        r_last_b <= r_sel_b;
      end
    end
  end

endmodule

// File: tb/tb_bulk_in_scheduler.sv
// Directed bench for bulk_in_scheduler: models both source FIFOs as byte counters
// and checks grants, packet lengths, tlast placement, flush ageing, abort and reset.
module tb_bulk_in_scheduler;

  localparam int LEVEL_BITS = 11;

  logic                  clock;
  logic                  reset;
  logic                  configured_i;
  logic                  usb_hs_i;
  logic                  usb_sof_i;
  logic                  blk_start_i;
  logic                  blk_cycle_i;
  logic [3:0]            blk_endpt_i;
  logic                  blk_in_ready_o;
  logic [1:0]            grant_o;
  logic [LEVEL_BITS-1:0] a_level_i;
  logic                  a_tvalid;
  logic                  a_tlast;
  logic [7:0]            a_tdata;
  logic                  a_tready;
  logic [LEVEL_BITS-1:0] b_level_i;
  logic                  b_tvalid;
  logic                  b_tlast;
  logic [7:0]            b_tdata;
  logic                  b_tready;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tkeep;
  logic [7:0]            m_tdata;
  logic                  m_tready;

  int n_checks = 0;
  int n_errors = 0;

  // Source model: remaining bytes, next byte value, and level at which tlast is shown.
  int a_lvl = 0, b_lvl = 0;
  int a_seq = 0, b_seq = 8'h80;
  int a_tlast_lvl = -1, b_tlast_lvl = -1;

  bulk_in_scheduler dut (
    .clock          (clock),
    .reset          (reset),
    .configured_i   (configured_i),
    .usb_hs_i       (usb_hs_i),
    .usb_sof_i      (usb_sof_i),
    .blk_start_i    (blk_start_i),
    .blk_cycle_i    (blk_cycle_i),
    .blk_endpt_i    (blk_endpt_i),
    .blk_in_ready_o (blk_in_ready_o),
    .grant_o        (grant_o),
    .a_level_i      (a_level_i),
    .a_tvalid       (a_tvalid),
    .a_tlast        (a_tlast),
    .a_tdata        (a_tdata),
    .a_tready       (a_tready),
    .b_level_i      (b_level_i),
    .b_tvalid       (b_tvalid),
    .b_tlast        (b_tlast),
    .b_tdata        (b_tdata),
    .b_tready       (b_tready),
    .m_tvalid       (m_tvalid),
    .m_tlast        (m_tlast),
    .m_tkeep        (m_tkeep),
    .m_tdata        (m_tdata),
    .m_tready       (m_tready)
  );

  initial clock = 1'b0;
  always #8 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    a_level_i = LEVEL_BITS'(a_lvl);
    a_tvalid  = (a_lvl > 0);
    a_tdata   = 8'(a_seq);
    a_tlast   = (a_lvl == a_tlast_lvl);
    b_level_i = LEVEL_BITS'(b_lvl);
    b_tvalid  = (b_lvl > 0);
    b_tdata   = 8'(b_seq);
    b_tlast   = (b_lvl == b_tlast_lvl);
  endtask

  // Every step leaves the bench 1 time unit after a falling edge.
  task automatic tick();
    @(negedge clock);
    drive_src();
    #1;
  endtask

  task automatic sof_pulse();
    usb_sof_i = 1'b1;
    tick();
    usb_sof_i = 1'b0;
    tick();
  endtask

  task automatic start_xfer(input logic [3:0] ep);
    blk_start_i = 1'b1;
    blk_cycle_i = 1'b1;
    blk_endpt_i = ep;
    tick();
    blk_start_i = 1'b0;
  endtask

  task automatic end_cycle();
    blk_cycle_i = 1'b0;
    tick();
  endtask

  // Drains bytes from the bridge side until tlast or stop_after bytes.
  task automatic collect(input string tag, input logic [1:0] exp_grant,
                         input int exp_len, input int exp_last, input int stop_after);
    int n, last_at, bad, budget;
    bit hs, lst;
    logic [7:0] exp_d;
    n = 0; last_at = -1; bad = 0; budget = 0;
    m_tready = 1'b1;
    check({tag, ".grant"}, 32'(grant_o), 32'(exp_grant));
    while (last_at < 0 && n < stop_after && budget < 3000) begin
      hs    = m_tvalid && m_tready;
      lst   = m_tlast;
      exp_d = exp_grant[1] ? 8'(b_seq) : 8'(a_seq);
      if ((exp_grant[1] ? a_tready : b_tready) !== 1'b0) bad++;
      if (hs) begin
        n++;
        if (m_tdata !== exp_d || m_tkeep !== 1'b1) bad++;
        if ((exp_grant[1] ? b_tready : a_tready) !== 1'b1) bad++;
        if (lst) last_at = n;
      end
      @(negedge clock);
      if (hs) begin
        if (exp_grant[1]) begin b_lvl--; b_seq++; end
        else              begin a_lvl--; a_seq++; end
      end
      drive_src();
      #1;
      budget++;
    end
    check({tag, ".bytes"}, 32'(n), 32'(exp_len));
    check({tag, ".tlast_at"}, 32'(last_at), 32'(exp_last));
    check({tag, ".data_errs"}, 32'(bad), 32'd0);
  endtask

  initial begin
    reset = 1'b1; configured_i = 1'b1; usb_hs_i = 1'b1; usb_sof_i = 1'b0;
    blk_start_i = 1'b0; blk_cycle_i = 1'b0; blk_endpt_i = 4'd0; m_tready = 1'b1;
    drive_src();
    tick();
    check("rst.ready", 32'(blk_in_ready_o), 32'd0);
    check("rst.grant", 32'(grant_o), 32'd0);
    check("rst.m_tvalid", 32'(m_tvalid), 32'd0);
    reset = 1'b0;
    tick();

    // HS, A holds 600: one full 512-byte packet, 88 left must age before it is eligible.
    a_lvl = 600;
    tick(); tick();
    check("t1.ready_pre", 32'(blk_in_ready_o), 32'd1);
    start_xfer(4'd1);
    collect("t1", 2'b01, 512, 512, 1000);
    end_cycle();
    tick();
    check("t1.a_left", 32'(a_level_i), 32'd88);
    check("t1.ready_88", 32'(blk_in_ready_o), 32'd0);
    for (int i = 0; i < 8; i++) sof_pulse();
    tick();
    check("t1.ready_aged", 32'(blk_in_ready_o), 32'd1);
    a_lvl = 0;
    tick();

    // FS, both sources hold 100 and are topped up: grants alternate A, B, A.
    reset = 1'b1; tick(); reset = 1'b0;
    usb_hs_i = 1'b0; a_lvl = 100; b_lvl = 100;
    tick();
    start_xfer(4'd1);
    collect("t2a", 2'b01, 64, 64, 1000);
    end_cycle(); a_lvl = 100; tick();
    start_xfer(4'd1);
    collect("t2b", 2'b10, 64, 64, 1000);
    end_cycle(); b_lvl = 100; tick();
    start_xfer(4'd1);
    collect("t2c", 2'b01, 64, 64, 1000);
    end_cycle();

    // HS, only B with 20 bytes: eligible on the 8th SOF, packet ends on byte 20.
    usb_hs_i = 1'b1; a_lvl = 0; b_lvl = 20;
    tick();
    for (int i = 0; i < 7; i++) sof_pulse();
    tick();
    check("t3.ready_7sof", 32'(blk_in_ready_o), 32'd0);
    sof_pulse();
    tick();
    check("t3.ready_8sof", 32'(blk_in_ready_o), 32'd1);
    start_xfer(4'd1);
    collect("t3", 2'b10, 20, 20, 1000);
    end_cycle();

    // B holds 30 and raises its own tlast on byte 12; the leftover must age from zero.
    b_lvl = 30; b_tlast_lvl = 19;
    tick();
    for (int i = 0; i < 8; i++) sof_pulse();
    start_xfer(4'd1);
    collect("t3s", 2'b10, 12, 12, 1000);
    end_cycle();
    b_tlast_lvl = -1;
    tick(); tick();
    check("t3s.b_left", 32'(b_level_i), 32'd18);
    check("t3s.ready_cleared", 32'(blk_in_ready_o), 32'd0);
    b_lvl = 0;

    // Start on another endpoint is ignored; unconfigured device is never ready.
    a_lvl = 600;
    tick(); tick();
    check("t4.ready", 32'(blk_in_ready_o), 32'd1);
    start_xfer(4'd2);
    check("t4.grant", 32'(grant_o), 32'd0);
    check("t4.a_tready", 32'(a_tready), 32'd0);
    check("t4.m_tvalid", 32'(m_tvalid), 32'd0);
    end_cycle();
    configured_i = 1'b0;
    tick(); tick();
    check("t4.ready_unconf", 32'(blk_in_ready_o), 32'd0);
    configured_i = 1'b1;

    // Abort after 100 bytes, then the same source (A) is favoured again.
    a_lvl = 1000; b_lvl = 1000;
    tick(); tick();
    start_xfer(4'd1);
    collect("t5", 2'b01, 100, -1, 100);
    m_tready = 1'b0; blk_cycle_i = 1'b0;
    tick();
    check("t5.grant_idle", 32'(grant_o), 32'd0);
    check("t5.m_tvalid_idle", 32'(m_tvalid), 32'd0);
    m_tready = 1'b1;
    tick();
    start_xfer(4'd1);
    collect("t5r", 2'b01, 512, 512, 1000);
    end_cycle();

    // Reset mid-packet: outputs drop at once, and the first tie then goes to A.
    a_lvl = 1000;
    tick();
    start_xfer(4'd1);
    collect("t6", 2'b10, 10, -1, 10);
    #3 reset = 1'b1;
    #1;
    check("t6.grant", 32'(grant_o), 32'd0);
    check("t6.m_tvalid", 32'(m_tvalid), 32'd0);
    check("t6.m_tkeep", 32'(m_tkeep), 32'd0);
    check("t6.m_tlast", 32'(m_tlast), 32'd0);
    check("t6.m_tdata", 32'(m_tdata), 32'd0);
    check("t6.b_tready", 32'(b_tready), 32'd0);
    check("t6.ready", 32'(blk_in_ready_o), 32'd0);
    @(negedge clock);
    reset = 1'b0; blk_cycle_i = 1'b0;
    drive_src();
    #1;
    tick();
    start_xfer(4'd1);
    check("t6.regrant_a", 32'(grant_o), 32'd1);
    end_cycle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bulk_in_scheduler.md
Name: bulk_in_scheduler

Overview:
- Shares the single USB bulk-IN datapath of `ulpi_axis_bridge` between two AXI4-Stream byte sources:
  - A: the loop-back `sync_fifo`.
  - B: the telemetry/hex stream.
- Drives the bridge's `blk_in_ready_i`.
- On each bulk-IN cycle, grants one source round-robin and cuts its data into one USB packet (512 B high-speed, 64 B full-speed, or shorter on flush).
- Sits between the source FIFOs and the bridge's `s_axis_*` port, in the `usb_clock` domain.

Parameters:
- ENDPOINT, 4'd1, bulk-IN endpoint number this scheduler serves.
- LEVEL_BITS, 11, width of the source FIFO level inputs.
- FLUSH_SOFS, 8, number of SOF pulses a non-empty, sub-packet source waits before it becomes eligible for a short packet (1..255).

Ports:
- clock  in  1  USB clock (60 MHz).
- reset  in  1  asynchronous, active-high.
- configured_i  in  1  device configured.
- usb_hs_i  in  1  high-speed enabled; selects 512-byte packets, else 64-byte.
- usb_sof_i  in  1  SOF pulse; rising edge counts as one tick.
- blk_start_i  in  1  bridge: bulk transaction starting.
- blk_cycle_i  in  1  bridge: bulk transaction active.
- blk_endpt_i  in  4  bridge: endpoint of current transaction.
- blk_in_ready_o  out  1  to bridge: a packet is available.
- grant_o  out  2  one-hot active source {B,A}; 2'b00 when idle.
- a_level_i  in  LEVEL_BITS  source A byte count.
- a_tvalid, a_tlast  in  1  source A stream.
- a_tdata  in  8  source A data.
- a_tready  out  1  source A ready.
- b_level_i, b_tvalid, b_tlast, b_tdata, b_tready: as for A.
- m_tvalid  out  1  to bridge.
- m_tlast  out  1  to bridge.
- m_tkeep  out  1  to bridge.
- m_tdata  out  8  to bridge.
- m_tready  in  1  from bridge.

Behaviour:
- Reset, asynchronous: all outputs, including `blk_in_ready_o` and `grant_o`, are 0.
  - State IDLE.
  - Round-robin pointer set so A wins the first tie.
  - Age counters 0.
- PKT = 512 if `usb_hs_i`, else 64. `usb_hs_i` is sampled only at grant.
- Age counter per source, 8-bit, saturating:
  - Increments on each SOF rising edge while 0 < level < PKT.
  - Clears when level == 0, when level >= PKT, or at that source's DONE.
- Eligibility: `elig_x = configured_i && (level_x >= PKT || (level_x != 0 && age_x >= FLUSH_SOFS))`.
- `blk_in_ready_o` is registered: `elig_a || elig_b`, one cycle latency. It is forced 0 while not IDLE.
- State machine IDLE -> XFER -> DONE -> IDLE.
  - IDLE:
    - Grant happens on `blk_start_i && blk_endpt_i == ENDPOINT && (elig_a || elig_b)`.
    - Grant goes to the eligible source, or the non-last-served one if both are eligible.
    - At grant, latch `len = min(level, PKT)` (10 bits) and clear the byte counter.
    - `grant_o` is valid the next cycle.
    - `blk_start_i` for another endpoint, or with no source eligible, is ignored; state stays IDLE.
  - XFER, combinational pass-through of the granted source:
    - `m_tvalid` = src tvalid and `src_tready = m_tready`; the ungranted source's tready is 0.
    - `m_tdata` = src data; `m_tkeep = m_tvalid`.
    - `m_tlast = src_tlast || count == len-1`.
    - The counter increments on each `m_tvalid && m_tready`.
    - A handshake with `m_tlast` goes to DONE.
  - DONE:
    - Set the pointer to the served source.
    - Clear its age.
    - Return to IDLE once `blk_cycle_i` is low.
- Abort: `blk_cycle_i` low while in XFER (timeout or bus error) -> IDLE.
  - The pointer is not advanced, so the same source is favoured next.
  - Bytes already consumed are lost; the bridge owns retransmission.
- Source tlast before len-1 ends the packet early (short packet); the remaining level is re-evaluated in IDLE.
- `len` never exceeds PKT. Level >= 1024 is clamped by the min.
- SOF coinciding with DONE: the clear wins.

Decomposition:
- Shared package `usb_defs`:
  - Constants `BLK_PKT_HS = 512` and `BLK_PKT_FS = 64`.
  - State encodings `ST_IDLE`, `ST_XFER`, `ST_DONE`.
- One natural sub-module, `flush_ager`: per-source SOF edge counter plus eligibility compare, instantiated twice.

Test Plan:
- HS, A level=600, B=0, start on EP1 -> `grant_o=01`, exactly 512 bytes out, `m_tlast` on byte 512, then `blk_in_ready_o` re-asserts (88 left is ineligible until 8 SOFs).
- FS, A=100 and B=100, three starts -> grants A, B, A; each packet 64 bytes.
- HS, B=20, no A; 7 SOFs -> ready stays 0; 8th SOF -> ready=1; start -> 20-byte packet, tlast on byte 20, B age cleared.
- Start with `blk_endpt_i=2` (ENDPOINT=1) -> no grant, no tready.
- Abort: drop `blk_cycle_i` after 100 of 512 bytes -> IDLE, `grant_o=00`; next start with both eligible -> same source regranted.
- Assert reset mid-XFER -> all outputs 0 immediately, asynchronously; after release the first tie goes to A.
